net_router_switch_alloc: RTL and testbench

Switch allocator for the 3-port ring router. It sits between the route units and the switch muxes. Each cycle it takes one request per input, each naming a destination output, and grants at most one input per output. Arbitration is round-robin per output, with an age-based starvation override. It drives the switch-mux selects and the input dequeue readies, and records illegal destinations in a sticky error flag.

---
 rtl/net_router_switch_alloc.sv | 122 ++++++++++++
 tb/tb_net_router_switch_alloc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_router_switch_alloc.sv
// Switch allocator for the 3-port ring router.
// Each output grants at most one input per cycle:
//   - Arbitration is round-robin per output.
//   - Starving inputs are searched ahead of the others.
// The grant path is purely combinational.
// Pointers, ages and the illegal-destination flag are registered.
module net_router_switch_alloc #(
  parameter int p_max_wait  = 7,
  parameter int p_age_nbits = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req_val,
  input  logic [5:0] req_dest,
  output logic [2:0] req_rdy,
  output logic [2:0] out_val,
  output logic [5:0] out_sel,
  input  logic [2:0] out_rdy,
  output logic [2:0] starving,
  output logic       err_sticky
);

  localparam logic [p_age_nbits-1:0] max_age = p_age_nbits'(p_max_wait);

  // Successor in the 0,1,2 ring.
  function automatic logic [1:0] next_idx(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [2:0] starve_int;  // age saturated, before reset gating
  logic [2:0] illegal;     // valid request naming output 3
  logic [2:0] gnt [3];     // one-hot granted input per output, only when transferring
  logic       err_sticky_reg;

  // ---------------------------------------------------------------
  // Per-output arbitration and round-robin pointer
  // ---------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_out
    logic [1:0] ptr_reg;
    logic [2:0] cand;
    logic [2:0] pool;
    logic [1:0] win;
    logic [1:0] ord1;
    logic [1:0] ord2;
    logic       any_cand;
    logic       xfer;

    assign cand[0] = req_val[0] && (req_dest[1:0] == 2'(gi));
    assign cand[1] = req_val[1] && (req_dest[3:2] == 2'(gi));
    assign cand[2] = req_val[2] && (req_dest[5:4] == 2'(gi));
    assign any_cand = |cand;
    assign ord1 = next_idx(ptr_reg);
    assign ord2 = next_idx(ord1);

    // Pick the first eligible input starting at ptr; starving candidates shadow the rest
    always_comb begin
      pool = ((cand & starve_int) != 3'b000) ? (cand & starve_int) : cand;
      win  = 2'd0;
      if (pool[ptr_reg]) begin
        win = ptr_reg;
      end else if (pool[ord1]) begin
        win = ord1;
      end else if (pool[ord2]) begin
        win = ord2;
      end
    end

    assign xfer                = reset && any_cand && out_rdy[gi];
    assign out_val[gi]         = reset && any_cand;
    assign out_sel[2*gi +: 2]  = (reset && any_cand) ? win : 2'd0;
    assign gnt[gi]             = xfer ? (3'b001 << win) : 3'b000;

    // Advance the pointer past the winner only when a message actually moves
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ptr_reg <= 2'd0;
      end else if (xfer) begin
        ptr_reg <= next_idx(win);
      end
    end
  end

  // Each input sits in at most one candidate set, so OR-ing the grants is exact
  assign req_rdy = gnt[0] | gnt[1] | gnt[2];

  // ---------------------------------------------------------------
  // Per-input age counters
  // ---------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    logic [p_age_nbits-1:0] age_reg;
    logic [1:0]             dest;

    assign dest           = req_dest[2*gi +: 2];
    assign illegal[gi]    = req_val[gi] && (dest == 2'd3);
    assign starve_int[gi] = (age_reg == max_age);

    // Age grows while a legal request waits, saturating; any dequeue or idle cycle clears it
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        age_reg <= '0;
      end else if (req_rdy[gi] || !req_val[gi] || (dest == 2'd3)) begin
        age_reg <= '0;
      end else if (age_reg != max_age) begin
        age_reg <= age_reg + 1'b1;
      end
    end
  end

  assign starving = reset ? starve_int : 3'b000;

  // Latch any illegal destination until the next reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sticky_reg <= 1'b0;
    end else if (|illegal) begin
      err_sticky_reg <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_net_router_switch_alloc.sv
// Randomized and directed bench for net_router_switch_alloc.
// A behavioural allocator model predicts the outputs every cycle.
// Directed scenarios pin the model with literal expectations.
module tb_net_router_switch_alloc;

  localparam int MW = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req_val = 3'b000;
  logic [5:0] req_dest = 6'd0;
  logic [2:0] out_rdy = 3'b000;
  logic [2:0] req_rdy;
  logic [2:0] out_val;
  logic [5:0] out_sel;
  logic [2:0] starving;
  logic       err_sticky;

  int tests = 0;
  int fails = 0;
  int m_ptr [3] = '{0, 0, 0};
  int m_age [3] = '{0, 0, 0};
  bit m_err = 1'b0;

  net_router_switch_alloc #(.p_max_wait(MW), .p_age_nbits(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_dest   (req_dest),
    .req_rdy    (req_rdy),
    .out_val    (out_val),
    .out_sel    (out_sel),
    .out_rdy    (out_rdy),
    .starving   (starving),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dest_of(input int i);
    logic [5:0] d;
    d = req_dest;
    return int'(d[2*i +: 2]);
  endfunction

  // Expected combinational outputs from the current inputs and model state
  function automatic void model_eval(output logic [2:0] rdy, output logic [2:0] val,
                                     output logic [5:0] sel);
    rdy = 3'b000;
    val = 3'b000;
    sel = 6'd0;
    if (reset) begin
      for (int o = 0; o < 3; o++) begin
        bit cand [3];
        int nst;
        bit found;
        nst = 0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
          cand[i] = req_val[i] && (dest_of(i) == o);
          if (cand[i] && m_age[i] == MW) nst++;
        end
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (m_ptr[o] + k) % 3;
          if (!found && cand[i] && (nst == 0 || m_age[i] == MW)) begin
            found = 1'b1;
            val[o] = 1'b1;
            sel[2*o +: 2] = 2'(i);
            if (out_rdy[o]) rdy[i] = 1'b1;
          end
        end
      end
    end
  endfunction

  // Model state advance on each clock edge, cleared asynchronously by reset
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < 3; i++) begin
          m_ptr[i] = 0;
          m_age[i] = 0;
        end
        m_err = 1'b0;
      end else begin
        logic [2:0] r;
        logic [2:0] v;
        logic [5:0] s;
        model_eval(r, v, s);
        for (int o = 0; o < 3; o++)
          if (v[o] && out_rdy[o]) m_ptr[o] = (int'(s[2*o +: 2]) + 1) % 3;
        for (int i = 0; i < 3; i++) begin
          if (req_val[i] && dest_of(i) == 3) m_err = 1'b1;
          if (r[i] || !req_val[i] || dest_of(i) == 3) m_age[i] = 0;
          else if (m_age[i] < MW) m_age[i] = m_age[i] + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      logic [2:0] er;
      logic [2:0] ev;
      logic [5:0] es;
      logic [2:0] est;
      @(negedge clk);
      model_eval(er, ev, es);
      for (int i = 0; i < 3; i++) est[i] = reset && (m_age[i] == MW);
      chk("req_rdy", 32'(req_rdy), 32'(er));
      chk("out_val", 32'(out_val), 32'(ev));
      chk("out_sel", 32'(out_sel), 32'(es));
      chk("starving", 32'(starving), 32'(est));
      chk("err_sticky", 32'(err_sticky), 32'(m_err));
      $display("[TB] t=%0t rst_n=%0b val=%b dest=%h rdy_in=%b -> req_rdy=%b out_val=%b out_sel=%h starv=%b err=%0b",
               $time, reset, req_val, req_dest, out_rdy, req_rdy, out_val, out_sel, starving, err_sticky);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for one cycle; returns just after the edge where reset is high again
  task automatic do_reset();
    step();
    reset = 1'b0;
    req_val = 3'b000;
    req_dest = 6'd0;
    out_rdy = 3'b000;
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset holds all grants off even with requests present
    reset = 1'b0;
    req_val = 3'b111;
    req_dest = 6'd0;
    out_rdy = 3'b111;
    repeat (2) @(negedge clk);
    chk("t1_out_val_in_reset", 32'(out_val), 32'd0);
    chk("t1_req_rdy_in_reset", 32'(req_rdy), 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t1_out_sel0", 32'(out_sel[1:0]), 32'd0);
    chk("t1_req_rdy", 32'(req_rdy), 32'b001);

    // Round-robin on output 1
    do_reset();
    req_val = 3'b111;
    req_dest = 6'b01_01_01;
    out_rdy = 3'b010;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("t2_winner", 32'(out_sel[3:2]), 32'(n % 3));
      chk("t2_req_rdy", 32'(req_rdy), 32'(1 << (n % 3)));
      step();
    end

    // Backpressure: held winner, ages saturate, then the same winner transfers
    do_reset();
    req_val = 3'b111;
    req_dest = 6'b01_01_01;
    out_rdy = 3'b000;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("t3_held_sel", 32'(out_sel[3:2]), 32'd0);
      chk("t3_no_rdy", 32'(req_rdy), 32'd0);
      step();
    end
    out_rdy = 3'b010;
    @(negedge clk);
    chk("t3_all_starving", 32'(starving), 32'b111);
    chk("t3_release_rdy", 32'(req_rdy), 32'b001);

    // Starvation override beats the round-robin pointer
    do_reset();
    req_val = 3'b101;
    req_dest = 6'd0;
    out_rdy = 3'b000;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      step();
    end
    out_rdy = 3'b001;
    @(negedge clk);
    chk("t4_starving", 32'(starving), 32'b101);
    chk("t4_first_rdy", 32'(req_rdy), 32'b001);
    step();
    req_val = 3'b110;
    req_dest = 6'd0;
    @(negedge clk);
    chk("t4_override_sel", 32'(out_sel[1:0]), 32'd2);
    chk("t4_override_rdy", 32'(req_rdy), 32'b100);

    // Parallel grant on disjoint outputs
    do_reset();
    req_val = 3'b111;
    req_dest = 6'b01_00_10;
    out_rdy = 3'b111;
    @(negedge clk);
    chk("t5_req_rdy", 32'(req_rdy), 32'b111);
    chk("t5_out_sel", 32'(out_sel), 32'(6'b00_10_01));

    // Illegal destination: never granted, flags the error from the next cycle
    do_reset();
    req_val = 3'b010;
    req_dest = 6'b00_11_00;
    out_rdy = 3'b111;
    @(negedge clk);
    chk("t6_rdy", 32'(req_rdy), 32'd0);
    chk("t6_val", 32'(out_val), 32'd0);
    chk("t6_err_same_cycle", 32'(err_sticky), 32'd0);
    step();
    req_val = 3'b000;
    @(negedge clk);
    chk("t6_err_next", 32'(err_sticky), 32'd1);
    chk("t6_no_age", 32'(starving), 32'd0);
    step();
    @(negedge clk);
    chk("t6_err_sticky", 32'(err_sticky), 32'd1);

    // Random traffic with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      step();
      if (!reset) reset = 1'b1;
      req_val = 3'($urandom);
      for (int i = 0; i < 3; i++)
        req_dest[2*i +: 2] = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
      if (n < 200) begin
        for (int o = 0; o < 3; o++) out_rdy[o] = ($urandom % 4 == 0);
      end else begin
        out_rdy = 3'($urandom);
      end
      if (reset && $urandom % 60 == 0) begin
        #2;
        reset = 1'b0;
      end
    end

    // A final reset clears the sticky flag
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("final_err_cleared", 32'(err_sticky), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
